// File: rtl/pool_feature_streamer_pkg.sv
// Shared defaults for the pooled-feature streamer (CO, OF_BW, POS and the
// position index width derived from POS).
package pool_feature_streamer_pkg;

  localparam int CoDefault   = 3;
  localparam int OfBwDefault = 16;
  localparam int PosDefault  = 16;

  // Index width for a power-of-two position count.
  function automatic int idx_bw(input int pos);
    return (pos > 1) ? $clog2(pos) : 1;
  endfunction

  localparam int IdxBwDefault = idx_bw(PosDefault);

endpackage

// File: rtl/pool_feature_streamer_bank.sv
// feature_bank: two banks of POS words each, one write port and one
// registered read port. The read register returns zero when not enabled so
// the streamed data bus is quiet between frames.
module feature_bank
  import pool_feature_streamer_pkg::*;
#(
  parameter int W   = CoDefault * OfBwDefault,
  parameter int POS = PosDefault
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic                       wr_bank_i,
  input  logic [$clog2(POS)-1:0]     wr_addr_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  input  logic                       rd_bank_i,
  input  logic [$clog2(POS)-1:0]     rd_addr_i,
  output logic [W-1:0]               rd_data_o
);

  logic [W-1:0] mem_q [2*POS];
  logic [W-1:0] rd_data_q, rd_data_d;

  // Storage array; contents need no reset because full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  // Read data selection for the output register.
  always_comb begin
    rd_data_d = '0;
    if (rd_en_i) begin
      rd_data_d = mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pool_feature_streamer.sv
// pool_feature_streamer: ping-pong frame buffer between max pooling and the
// FC1 accumulator. Optional sticky drop flag o_overflow is built only when
// STREAM_OVF_FLAG_EN is defined.
module pool_feature_streamer
  import pool_feature_streamer_pkg::*;
#(
  parameter int CO    = CoDefault,
  parameter int OF_BW = OfBwDefault,
  parameter int POS   = PosDefault
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_in_valid,
  input  logic [CO*OF_BW-1:0]       i_in_pooling,
  output logic                      o_in_ready,
  output logic                      o_ot_valid,
  output logic [CO*OF_BW-1:0]       o_ot_pooling,
  output logic [$clog2(POS)-1:0]    o_ot_idx,
  output logic                      o_ot_last
`ifdef STREAM_OVF_FLAG_EN
  ,
  output logic                      o_overflow
`endif
);

  localparam int W      = CO * OF_BW;
  localparam int IDX_BW = $clog2(POS);
  localparam logic [IDX_BW-1:0] IdxMax = IDX_BW'(POS - 1);
  localparam logic [IDX_BW-1:0] IdxOne = IDX_BW'(1);

  typedef enum logic {StIdle, StStream} rd_state_e;

  rd_state_e         state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [IDX_BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic              in_ready;
  logic              wr_fire;
  logic              wr_done;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic              rd_last;
  logic              other_full;
  logic              rd_en;
  logic              rd_bank_sel;
  logic [IDX_BW-1:0] rd_addr;

  // Write side: accept, advance pointer, mark bank full on the final word.
  always_comb begin
    in_ready  = !full_q[wr_bank_q];
    wr_fire   = i_in_valid && in_ready;
    wr_done   = wr_fire && (wr_ptr_q == IdxMax);
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + IdxOne;
    end
    if (wr_done) begin
      wr_ptr_d           = '0;
      wr_bank_d          = !wr_bank_q;
      full_set[wr_bank_q] = 1'b1;
    end
  end

  // Read FSM next state; a bank completing this edge counts so frames chain
  // without a bubble.
  always_comb begin
    rd_last    = (state_q == StStream) && (rd_ptr_q == IdxMax);
    other_full = full_q[!rd_bank_q] || full_set[!rd_bank_q];
    state_d    = state_q;
    unique case (state_q)
      StIdle:   if (full_q[rd_bank_q]) state_d = StStream;
      StStream: if (rd_last) state_d = other_full ? StStream : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Read FSM outputs: read request, pointer/bank update and flag release.
  always_comb begin
    rd_en       = 1'b0;
    rd_bank_sel = rd_bank_q;
    rd_addr     = '0;
    rd_ptr_d    = rd_ptr_q;
    rd_bank_d   = rd_bank_q;
    full_clr    = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          rd_en    = 1'b1;
          rd_ptr_d = '0;
        end
      end
      StStream: begin
        if (rd_last) begin
          full_clr[rd_bank_q] = 1'b1;
          rd_bank_d           = !rd_bank_q;
          rd_ptr_d            = '0;
          if (other_full) begin
            rd_en       = 1'b1;
            rd_bank_sel = !rd_bank_q;
          end
        end else begin
          rd_en    = 1'b1;
          rd_addr  = rd_ptr_q + IdxOne;
          rd_ptr_d = rd_ptr_q + IdxOne;
        end
      end
      default: ;
    endcase
    valid_d = rd_en;
    last_d  = rd_en && (rd_ptr_d == IdxMax);
    full_d  = (full_q & ~full_clr) | full_set;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointers, flags and registered output controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_ptr_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_ptr_q  <= rd_ptr_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

`ifdef STREAM_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Sticky drop flag, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q || (i_in_valid && !in_ready);
  end

  // Drop flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`endif

  feature_bank #(
    .W   (W),
    .POS (POS)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_fire),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (i_in_pooling),
    .rd_en_i   (rd_en),
    .rd_bank_i (rd_bank_sel),
    .rd_addr_i (rd_addr),
    .rd_data_o (o_ot_pooling)
  );

  assign o_in_ready = in_ready;
  assign o_ot_valid = valid_q;
  assign o_ot_idx   = rd_ptr_q;
  assign o_ot_last  = last_q;

endmodule
